mult_operand_loader: RTL and testbench
======================================

# mult_operand_loader

Bit-serial operand front end for the sequential shift-add multiplier in the SPI multiplier peripheral. Accepts a framed serial bit stream from the SPI receive path, assembles operands A and B, presents them as stable parallel words, issues the one-cycle `start` pulse, and holds off further launches until the multiplier reports `done`. It sits directly upstream of the multiplier and drives its `A`, `B` and `start` inputs.

## Interface
- `width`, default 4: operand width in bits; must match the downstream multiplier's `width`.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `cs_active`  input  1  frame qualifier from the SPI slave; high while a frame is in progress.
- `sin`  input  1  serial data bit, MSB first, A before B.
- `sin_valid`  input  1  one-cycle strobe; `sin` is valid on this cycle.
- `mult_done`  input  1  the multiplier's `done`; high for one cycle when its result is valid.
- `A`  output  width  operand A to the multiplier; registered.
- `B`  output  width  operand B to the multiplier; registered.
- `start`  output  1  one-cycle launch pulse to the multiplier; registered.
- `busy`  output  1  high from launch until `mult_done` is seen.
- `overrun`  output  1  sticky flag: a bit arrived while busy (see Configuration).

## Operation
- States: COLLECT, LAUNCH, BUSY. Reset state is COLLECT.
- Reset values: `A`=0, `B`=0, `start`=0, `busy`=0, `overrun`=0, bit counter 0, shift register 0.
- COLLECT: on each cycle with `sin_valid && cs_active`, shift `sin` into the LSB of a 2*width-bit shift register and increment the bit counter.
  - When the accepted bit is bit number 2*width, the state goes to LAUNCH and the counter clears.
  - `cs_active` low in COLLECT clears the counter. A partial frame is discarded. The shift register contents are don't-care.
  - `sin_valid` with `cs_active` low is ignored.
- LAUNCH: lasts exactly one cycle.
  - `A` is loaded from shift register bits [2*width-1:width] and `B` from bits [width-1:0].
  - `start` is 1 and `busy` is 1. The next state is BUSY.
- BUSY: `start`=0 and `busy`=1. `A` and `B` hold, because the multiplier loads them on its start cycle and they must not change mid-operation.
  - `mult_done`=1 moves the state to COLLECT and drops `busy` on the next edge.
  - `sin_valid` in LAUNCH or BUSY: the bit is dropped and the counter does not advance. `overrun` is set if enabled.
- `mult_done` seen in COLLECT or LAUNCH is ignored.
- `A` and `B` change only on entry to LAUNCH. Between frames they hold their last values.
- Bit counter width is $clog2(2*width+1). No wrap-around is possible because the counter clears at 2*width.

## Timing
- Let cycle N be the cycle whose edge accepts the last bit. Then:
  - `start`=1 and `A`/`B` hold the new values during cycle N+1.
  - `start` returns to 0 in cycle N+2.
- Latency from the final bit strobe to `start` is 1 cycle.
- If `mult_done` is high in cycle M while BUSY, `busy`=0 in cycle M+1. The first bit of the next frame is accepted from cycle M+1.
- Same-cycle `cs_active` fall and last `sin_valid`: the bit is ignored and the frame is discarded.
- `reset` asserted mid-frame or while BUSY: all outputs immediately return to their reset values. Any in-flight multiplication result is abandoned by this block.

## Configuration
- `MULT_LOADER_OVERRUN_EN` defined:
  - `overrun` is set by any `sin_valid` with `cs_active` in LAUNCH or BUSY.
  - It clears only on `reset`, or on the first accepted bit of a new frame when `cs_active` has been low for at least one cycle since the flag was set.
- Not defined: `overrun` is tied to 0 and no flag logic is built. Dropping of bits during BUSY is unchanged.

## Structure
- Shared package/header: state encodings `LD_COLLECT`=2'b00, `LD_LAUNCH`=2'b01, `LD_BUSY`=2'b10.
- One natural sub-module: the 2*width serial-in/parallel-out shift register, `sipo_shiftreg`. The counter and FSM live in the top module.

## Test plan
- width=4. Reset, then shift 0,0,1,1,0,1,0,1 with `cs_active` high. Expected: `start`=1 for exactly one cycle, one cycle after the 8th strobe; `A`=3, `B`=5; `busy`=1 until `mult_done` is pulsed, then 0 on the next cycle.
- Send 5 bits, drop `cs_active`, then send a full frame 1111_0010. Expected: exactly one `start`, with `A`=15 and `B`=2.
- Pulse `sin_valid` 3 times while BUSY. Expected: `A` and `B` unchanged and no `start`; with the macro, `overrun`=1 and it stays set after `mult_done`. Then drop `cs_active` and send a new frame: `overrun` clears on its first accepted bit.
- Assert `reset` in the cycle after the 6th bit, then send 1000_0001. Expected: all outputs 0 immediately; after the frame, `A`=8 and `B`=1.
- Drive `mult_done` high while COLLECT mid-frame. Expected: no state change; the frame completes normally.
- Back-to-back: pulse `mult_done` and start the next frame in the following cycle. Expected: the second `start` occurs 1 cycle after that frame's 8th bit.

Source files
------------

// File: rtl/mult_operand_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mult_operand_loader_pkg
// Brief   : Shared state encodings for the multiplier operand loader.
// Revision: 1.0
// ============================================================================
package mult_operand_loader_pkg;

    typedef enum logic [1:0] {
        LD_COLLECT = 2'b00,
        LD_LAUNCH  = 2'b01,
        LD_BUSY    = 2'b10
    } ld_state_e;

    // Counter must hold the value 2*width.
    function automatic int ld_cnt_width(input int w);
        return $clog2(2 * w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_operand_loader_if.sv
`default_nettype none
// ============================================================================
// Module  : mult_operand_loader_if
// Brief   : Serial-in / operand-out bundle between SPI receive path,
//           operand loader and shift-add multiplier.
// Revision: 1.0
// ============================================================================
interface mult_operand_loader_if #(
    parameter int width = 4
);
    logic             cs_active;
    logic             sin;
    logic             sin_valid;
    logic             mult_done;
    logic [width-1:0] A;
    logic [width-1:0] B;
    logic             start;
    logic             busy;
    logic             overrun;

    modport master (
        output cs_active, sin, sin_valid, mult_done,
        input  A, B, start, busy, overrun
    );

    modport slave (
        input  cs_active, sin, sin_valid, mult_done,
        output A, B, start, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/mult_operand_loader_sipo_shiftreg.sv
`default_nettype none
// ============================================================================
// Module  : sipo_shiftreg
// Brief   : Serial-in/parallel-out shift register, new bit enters the LSB.
// Revision: 1.0
// ============================================================================
module sipo_shiftreg #(
    parameter int DEPTH = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             shift_en_i,
    input  wire logic             bit_i,
    output logic      [DEPTH-1:0] word_d_o
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    assign sr_d     = {sr_q[DEPTH-2:0], bit_i};
    // The post-shift word lets the parent capture operands on the same edge
    // that accepts the final bit.
    assign word_d_o = sr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else if (shift_en_i) begin
            sr_q <= sr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_operand_loader.sv
`default_nettype none
// ============================================================================
// Module  : mult_operand_loader
// Brief   : Assembles serial A/B operands, launches the multiplier and holds
//           off until done. Optional sticky overrun flag: MULT_LOADER_OVERRUN_EN.
// Revision: 1.0
// ============================================================================
module mult_operand_loader
    import mult_operand_loader_pkg::*;
#(
    parameter int width = 4
) (
    input  wire logic              clk,
    input  wire logic              reset,
    mult_operand_loader_if.slave   bus
);

    localparam int                FRAME_BITS = 2 * width;
    localparam int                CNT_W      = ld_cnt_width(width);
    localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(FRAME_BITS - 1);

    ld_state_e              state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [width-1:0]       a_q;
    logic [width-1:0]       b_q;
    logic                   start_q;
    logic                   busy_q;
    logic [FRAME_BITS-1:0]  word_d;
    logic                   accept;

    assign accept = (state_q == LD_COLLECT) && bus.sin_valid && bus.cs_active;

    sipo_shiftreg #(
        .DEPTH (FRAME_BITS)
    ) u_sipo (
        .clk        (clk),
        .reset      (reset),
        .shift_en_i (accept),
        .bit_i      (bus.sin),
        .word_d_o   (word_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LD_COLLECT;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                LD_COLLECT: begin
                    if (!bus.cs_active) begin
                        cnt_q <= '0;
                    end else if (bus.sin_valid) begin
                        if (cnt_q == LAST_IDX) begin
                            cnt_q   <= '0;
                            a_q     <= word_d[FRAME_BITS-1:width];
                            b_q     <= word_d[width-1:0];
                            start_q <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= LD_LAUNCH;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                LD_LAUNCH: begin
                    start_q <= 1'b0;
                    state_q <= LD_BUSY;
                end
                LD_BUSY: begin
                    if (bus.mult_done) begin
                        busy_q  <= 1'b0;
                        state_q <= LD_COLLECT;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    start_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= LD_COLLECT;
                end
            endcase
        end
    end

    assign bus.A     = a_q;
    assign bus.B     = b_q;
    assign bus.start = start_q;
    assign bus.busy  = busy_q;

`ifdef MULT_LOADER_OVERRUN_EN
    logic overrun_q;
    logic cs_seen_low_q;
    logic drop;

    assign drop = (state_q != LD_COLLECT) && bus.sin_valid && bus.cs_active;

    // Clearing needs a frame gap after the overrun, so a stream that kept
    // cs_active high across the busy window keeps reporting the error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q     <= 1'b0;
            cs_seen_low_q <= 1'b0;
        end else if (drop) begin
            overrun_q     <= 1'b1;
            cs_seen_low_q <= 1'b0;
        end else begin
            if (accept && cs_seen_low_q) begin
                overrun_q <= 1'b0;
            end
            if (!bus.cs_active) begin
                cs_seen_low_q <= 1'b1;
            end
        end
    end

    assign bus.overrun = overrun_q;
`else
    assign bus.overrun = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_operand_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_mult_operand_loader
// Brief   : Directed and random checks of mult_operand_loader against a
//           frame-level reference model.
// Revision: 1.0
// ============================================================================
module tb_mult_operand_loader;

    localparam int W = 4;
`ifdef MULT_LOADER_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mult_operand_loader_if #(.width(W)) bus ();

    mult_operand_loader #(.width(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int starts = 0;

    // Reference model: operands, launch/busy status, overrun, bits of the frame so far
    logic [W-1:0] m_a, m_b;
    bit           m_start, m_busy, m_ovr, m_seen_low;
    bit           frame[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_a = '0; m_b = '0;
        m_start = 0; m_busy = 0; m_ovr = 0; m_seen_low = 0;
        frame.delete();
    endtask

    task automatic model_step(input bit cs, input bit s, input bit v, input bit d);
        logic [2*W-1:0] word;
        if (m_start || m_busy) begin
            if (v && cs && OVR_EN) begin
                m_ovr = 1;
                m_seen_low = 0;
            end
            if (m_start) m_start = 0;
            else if (d) m_busy = 0;
        end else if (!cs) begin
            frame.delete();
        end else if (v) begin
            if (m_seen_low) m_ovr = 0;
            frame.push_back(s);
            if (frame.size() == 2 * W) begin
                word = '0;
                foreach (frame[i]) word = (word << 1) | (2*W)'(frame[i]);
                m_a = word / (2 ** W);
                m_b = word % (2 ** W);
                m_start = 1;
                m_busy = 1;
                frame.delete();
            end
        end
        if (!cs) m_seen_low = 1;
    endtask

    task automatic check_all();
        chk("A", 32'(bus.A), 32'(m_a));
        chk("B", 32'(bus.B), 32'(m_b));
        chk("start", 32'(bus.start), 32'(m_start));
        chk("busy", 32'(bus.busy), 32'(m_busy));
        chk("overrun", 32'(bus.overrun), 32'(m_ovr));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic step(input bit cs, input bit s, input bit v, input bit d);
        bus.cs_active = cs; bus.sin = s; bus.sin_valid = v; bus.mult_done = d;
        @(posedge clk);
        model_step(cs, s, v, d);
        #1;
        if (bus.start === 1'b1) starts++;
        check_all();
    endtask

    task automatic send_frame(input logic [2*W-1:0] bits);
        for (int i = 2*W-1; i >= 0; i--) step(1, bits[i], 1, 0);
    endtask

    task automatic async_reset(input string tag);
        bus.sin_valid = 0; bus.mult_done = 0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk({tag, "_A"}, 32'(bus.A), 0);
        chk({tag, "_B"}, 32'(bus.B), 0);
        chk({tag, "_start"}, 32'(bus.start), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_ovr"}, 32'(bus.overrun), 0);
        #2 reset = 1'b0;
    endtask

    initial begin
        logic [7:0] part;
        reset = 1'b1;
        bus.cs_active = 0; bus.sin = 0; bus.sin_valid = 0; bus.mult_done = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #3 reset = 1'b0;

        // First frame 0011_0101
        send_frame(8'b0011_0101);
        chk("f1_start", 32'(bus.start), 1);
        chk("f1_A", 32'(bus.A), 3);
        chk("f1_B", 32'(bus.B), 5);
        step(1, 0, 0, 0);
        chk("f1_start_drop", 32'(bus.start), 0);
        chk("f1_busy", 32'(bus.busy), 1);
        step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        chk("f1_busy_clear", 32'(bus.busy), 0);

        // Partial frame discarded by cs_active low
        part = 8'b1011_0000;
        starts = 0;
        for (int i = 7; i >= 3; i--) step(1, part[i], 1, 0);
        step(0, 0, 0, 0);
        send_frame(8'b1111_0010);
        chk("f2_A", 32'(bus.A), 15);
        chk("f2_B", 32'(bus.B), 2);
        step(1, 0, 0, 0);

        // Bits during BUSY are dropped
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 1, 0);
            step(1, 0, 0, 0);
        end
        chk("f2_one_start", 32'(starts), 1);
        chk("busy_A_hold", 32'(bus.A), 15);
        chk("busy_B_hold", 32'(bus.B), 2);
        chk("busy_ovr", 32'(bus.overrun), 32'(OVR_EN));
        step(1, 0, 0, 1);
        chk("ovr_after_done", 32'(bus.overrun), 32'(OVR_EN));
        step(0, 0, 0, 0);
        step(1, 1, 1, 0);
        chk("ovr_cleared", 32'(bus.overrun), 0);
        part = 8'b1010_0110;
        for (int i = 6; i >= 0; i--) step(1, part[i], 1, 0);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);

        // Reset after the 6th bit of a frame
        part = 8'b0011_1100;
        for (int i = 7; i >= 2; i--) step(1, part[i], 1, 0);
        async_reset("rst_mid");
        send_frame(8'b1000_0001);
        chk("f3_A", 32'(bus.A), 8);
        chk("f3_B", 32'(bus.B), 1);
        step(1, 1, 1, 0);
        async_reset("rst_busy");

        // mult_done while collecting is ignored
        part = 8'b0101_1010;
        for (int i = 7; i >= 4; i--) step(1, part[i], 1, 0);
        step(1, 0, 0, 1);
        step(1, part[3], 1, 1);
        for (int i = 2; i >= 0; i--) step(1, part[i], 1, 0);
        chk("f4_A", 32'(bus.A), 5);
        chk("f4_B", 32'(bus.B), 10);
        step(1, 0, 0, 0);

        // Back-to-back frame right after mult_done
        step(1, 0, 0, 1);
        part = 8'b1100_0011;
        for (int i = 7; i >= 1; i--) step(1, part[i], 1, 0);
        chk("b2b_no_early_start", 32'(bus.start), 0);
        step(1, part[0], 1, 0);
        chk("b2b_start", 32'(bus.start), 1);
        chk("b2b_A", 32'(bus.A), 12);
        chk("b2b_B", 32'(bus.B), 3);
        step(1, 0, 0, 0);
        step(1, 0, 0, 1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 19) != 0, 1'($urandom), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 9) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
